// File: rtl/ssd_msg_scroller_if.sv
// Control, buffer-write and display-pin bundle for the scrolling 7-segment driver.
// The master drives message/scroll controls; the slave (the driver) owns the pins.
interface ssd_msg_scroller_if #(
  parameter int NUM_DIGITS = 4,
  parameter int AW         = 3
);
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [4:0]            wr_char;
  logic                  scroll_en;
  logic                  scroll_dir;
  logic                  pos_load;
  logic [AW-1:0]         pos_val;
  logic [6:0]            seg;
  logic                  dp;
  logic [NUM_DIGITS-1:0] an;
  logic [AW-1:0]         pos;
  logic                  scroll_tick;

  modport master (
    output wr_en, wr_addr, wr_char, scroll_en, scroll_dir, pos_load, pos_val,
    input  seg, dp, an, pos, scroll_tick
  );

  modport slave (
    input  wr_en, wr_addr, wr_char, scroll_en, scroll_dir, pos_load, pos_val,
    output seg, dp, an, pos, scroll_tick
  );
endinterface

// File: rtl/ssd_msg_scroller.sv
// Multiplexed common-anode 7-segment driver showing a NUM_DIGITS window of a
// writable MSG_LEN-character buffer that can scroll, pause and be repositioned.
module ssd_msg_scroller #(
  parameter int NUM_DIGITS  = 4,
  parameter int MSG_LEN     = 8,
  parameter int REFRESH_DIV = 1024,
  parameter int SCROLL_DIV  = 30000000,
  parameter int AW          = $clog2(MSG_LEN)
) (
  input logic               clk,
  input logic               rst,
  ssd_msg_scroller_if.slave bus
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int IW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam logic [4:0] BLANK_CODE = 5'd16;

  function automatic logic [6:0] decode(input logic [4:0] code);
    logic [6:0] s;
    case (code)
      5'd0:    s = 7'b1000000;
      5'd1:    s = 7'b1111001;
      5'd2:    s = 7'b0100100;
      5'd3:    s = 7'b0110000;
      5'd4:    s = 7'b0011001;
      5'd5:    s = 7'b0010010;
      5'd6:    s = 7'b0000010;
      5'd7:    s = 7'b1111000;
      5'd8:    s = 7'b0000000;
      5'd9:    s = 7'b0010000;
      5'd10:   s = 7'b0001000;
      5'd11:   s = 7'b0000011;
      5'd12:   s = 7'b1000110;
      5'd13:   s = 7'b0100001;
      5'd14:   s = 7'b0000110;
      5'd15:   s = 7'b0001110;
      5'd17:   s = 7'b1000111;
      5'd18:   s = 7'b1000110;
      5'd19:   s = 7'b0001100;
      5'd20:   s = 7'b0001001;
      5'd21:   s = 7'b1000001;
      5'd22:   s = 7'b0111111;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [4:0]            buf_r [MSG_LEN];
  logic [RW-1:0]         refresh_cnt_r;
  logic [SW-1:0]         scroll_cnt_r;
  logic [DW-1:0]         digit_r;
  logic [AW-1:0]         pos_r;
  logic [6:0]            seg_r;
  logic [NUM_DIGITS-1:0] an_r;
  logic                  tick_r;

  logic [AW:0]           idx_sum_s;
  logic [AW:0]           idx_s;
  logic [AW-1:0]         pos_step_s;
  logic [AW-1:0]         pos_load_val_s;
  logic                  wr_ok_s;
  logic                  refresh_tc_s;
  logic                  scroll_tc_s;

  // Window index of the digit being refreshed, next scroll position and input qualification.
  always_comb begin
    idx_sum_s = {1'b0, pos_r} + (AW+1)'(NUM_DIGITS-1) - (AW+1)'(digit_r);
    if (idx_sum_s >= (AW+1)'(MSG_LEN)) begin
      idx_s = idx_sum_s - (AW+1)'(MSG_LEN);
    end else begin
      idx_s = idx_sum_s;
    end

    if (bus.scroll_dir) begin
      if (pos_r == AW'(0)) begin
        pos_step_s = AW'(MSG_LEN-1);
      end else begin
        pos_step_s = pos_r - AW'(1);
      end
    end else begin
      if (pos_r == AW'(MSG_LEN-1)) begin
        pos_step_s = AW'(0);
      end else begin
        pos_step_s = pos_r + AW'(1);
      end
    end

    if ({1'b0, bus.pos_val} >= (AW+1)'(MSG_LEN)) begin
      pos_load_val_s = AW'(0);
    end else begin
      pos_load_val_s = bus.pos_val;
    end

    wr_ok_s      = bus.wr_en && ({1'b0, bus.wr_addr} < (AW+1)'(MSG_LEN));
    refresh_tc_s = (refresh_cnt_r == RW'(REFRESH_DIV-1));
    scroll_tc_s  = (scroll_cnt_r == SW'(SCROLL_DIV-1));
  end

  // Message buffer; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        buf_r[i] <= BLANK_CODE;
      end
    end else if (wr_ok_s) begin
      buf_r[IW'(bus.wr_addr)] <= bus.wr_char;
    end
  end

  // Digit multiplexing: the digit selected before the advance is the one lit on this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt_r <= RW'(0);
      digit_r       <= DW'(0);
      seg_r         <= 7'b1111111;
      an_r          <= {NUM_DIGITS{1'b1}};
    end else if (refresh_tc_s) begin
      refresh_cnt_r <= RW'(0);
      seg_r         <= decode(buf_r[IW'(idx_s)]);
      an_r          <= ~(NUM_DIGITS'(1) << digit_r);
      if (digit_r == DW'(NUM_DIGITS-1)) begin
        digit_r <= DW'(0);
      end else begin
        digit_r <= digit_r + DW'(1);
      end
    end else begin
      refresh_cnt_r <= refresh_cnt_r + RW'(1);
    end
  end

  // Scroll timer and window position; a load wins over a coincident step and never ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      scroll_cnt_r <= SW'(0);
      pos_r        <= AW'(0);
      tick_r       <= 1'b0;
    end else if (bus.pos_load) begin
      scroll_cnt_r <= SW'(0);
      pos_r        <= pos_load_val_s;
      tick_r       <= 1'b0;
    end else if (bus.scroll_en && scroll_tc_s) begin
      scroll_cnt_r <= SW'(0);
      pos_r        <= pos_step_s;
      tick_r       <= 1'b1;
    end else if (bus.scroll_en) begin
      scroll_cnt_r <= scroll_cnt_r + SW'(1);
      tick_r       <= 1'b0;
    end else begin
      tick_r       <= 1'b0;
    end
  end

  assign bus.seg         = seg_r;
  assign bus.an          = an_r;
  assign bus.pos         = pos_r;
  assign bus.scroll_tick = tick_r;
  assign bus.dp          = 1'b1;

endmodule
